fir_coef_loader: RTL and testbench
==================================

# fir_coef_loader

Register-bus sequencer that owns the coefficient/configuration port of the multi-channel FIR (`fir_mc`).
- A host fills an internal coefficient buffer, then pulses `start`.
- The block streams every tap into the FIR register space with full `reg_ready` handshaking, then writes the control word.
- While it runs it asserts `pcm_hold` so upstream logic gates PCM samples off during the reload.
- It sits between the host/CPU register domain and the FIR register port, on the FIR register clock.

## Interface
Parameters:
- `SHIFT_DEFAULT`, 13: value used when `shift_sel` = 0.
- `CTRL_ADDR`, 8'hFF: FIR control-word address.
- `TIMEOUT`, 1023: maximum cycles to wait for `reg_ready` per access.

Ports (the clock is the FIR register clock; single clock; reset is synchronous and active-low):
- `clk`  in  1: register-domain clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `coef_wr`  in  1: host buffer write strobe.
- `coef_addr`  in  8: host buffer address.
- `coef_data`  in  32: host buffer data.
- `tap_len`  in  8: number of taps to load; sampled at accepted `start`.
- `shift`  in  4: output shift; sampled at accepted `start`.
- `shift_sel`  in  1: 1 = use `shift`, 0 = use `SHIFT_DEFAULT`.
- `start`  in  1: single-cycle load request.
- `busy`  out  1: load in progress.
- `done`  out  1: single-cycle completion pulse.
- `error`  out  3: sticky status; [0] timeout, [1] verify mismatch, [2] bad length.
- `pcm_hold`  out  1: request to gate `pcm_in_valid` upstream.
- `reg_addr`  out  8: FIR register address.
- `reg_wr`  out  1: FIR register write request.
- `reg_rd`  out  1: FIR register read request.
- `reg_ready`  in  1: FIR register access accepted.
- `reg_writedata`  out  32: FIR register write data.
- `reg_readdata`  in  32: FIR register read data.

## Operation
States and transitions:
- IDLE: `start` accepted, `tap_len`/`shift` latched, `error` cleared, `idx` = 0, go to FETCH. If the latched `tap_len` = 0, go to DONE with `error[2]` set and no bus activity.
- FETCH: buffer read at `idx`; go to WRITE.
- WRITE: `reg_wr`=1, `reg_addr`=`idx`, `reg_writedata`=buffer word.
  - On `reg_ready`: go to VRD if verify is compiled in.
  - Otherwise, if `idx` = `tap_len`-1, go to COMMIT; else `idx`++ and go to FETCH.
- VRD (macro only): `reg_rd`=1, `reg_addr`=`idx`.
  - On `reg_ready`, compare `reg_readdata` with the written word; a mismatch sets `error[1]`.
  - Then continue exactly as WRITE would.
- COMMIT: `reg_wr`=1, `reg_addr`=`CTRL_ADDR`, `reg_writedata` = zero-extended {1'b0, shift[3:0], tap_len[7:0], 8'd1}. On `reg_ready`, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.

Rules:
- `busy` and `pcm_hold` are 1 in every state except IDLE.
- Bus outputs are driven from registered state. `reg_addr`/`reg_writedata` stay stable while `reg_wr` or `reg_rd` is high. At most one of `reg_wr`/`reg_rd` is high at a time.
- Timeout: a per-access counter clears on entering WRITE, VRD or COMMIT. If it reaches `TIMEOUT` without `reg_ready`, drop the request, set `error[0]`, go to DONE, and skip the remaining taps and the commit.
- `start` while busy: ignored.
- `coef_wr` while busy: ignored; the buffer is unchanged.
- `coef_wr` and `start` in the same IDLE cycle: the write lands first and the load uses the new word.
- `error` holds until the next accepted `start`.
- `rst_n`=0 at any time: next edge gives IDLE, and every output is 0 (including `reg_addr` and `reg_writedata`).
  - The buffer contents are not reset.
  - A partial load leaves the FIR in whatever state the last accepted write produced; the host must restart.

## Timing
- Buffer read latency is 1 cycle.
- With `reg_ready` held high and verify off, measured from the `start` edge (cycle 0):
  - tap k written at cycle 2+2k;
  - COMMIT at cycle 2N+1;
  - `done` at cycle 2N+2;
  - `busy` falls at cycle 2N+3.
- With verify on, each tap costs 3 cycles.
- Each wait on `reg_ready` adds cycles one-for-one.
- Bad length: `done` at cycle 1.

## Configuration
- `FIR_LOAD_VERIFY_EN` defined: VRD state present; each tap is read back and compared, and `error[1]` is live.
- `FIR_LOAD_VERIFY_EN` undefined: no VRD state; `reg_rd` is tied 0, `error[1]` is tied 0, and `reg_readdata` is unused.

## Structure
- Shared package `fir_pkg` holds:
  - the state enum;
  - the `CTRL_ADDR` default;
  - control-word field positions: [19:16] shift, [15:8] tap_len, [7:0] enable;
  - the error bit indices.
- Sub-module `fir_coef_ram`: 256x32 simple dual-port RAM, host write port, registered read, no reset.

## Test plan
- 4 taps 0x11/0x22/0x33/0x44, `shift_sel`=0, `reg_ready`=1 -> writes to addr 0..3 in order, then addr 0xFF data 0x000D0401; `done` at cycle 10; `pcm_hold` high cycles 1-10; `error`=0.
- Same load with `reg_ready` low 3 cycles per access -> addr/data stable during each stall, exactly 5 writes, `done` at cycle 25.
- `TIMEOUT`=15 with `reg_ready` stuck 0 -> `reg_wr` drops after 16 cycles, `error`=3'b001, `done` pulses, no COMMIT.
- `tap_len`=0 -> `done` at cycle 1, `error`=3'b100, `reg_wr` never asserted.
- During a load: a second `start` and a `coef_wr` are ignored; then `rst_n` low at tap 2 -> next edge `reg_wr`=0, `busy`=0, and buffer contents intact on re-read.
- `FIR_LOAD_VERIFY_EN` with the slave returning corrupted data for tap 2 -> `error`=3'b010, all taps and the control word still written.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR coefficient loader.
//   - loader state encoding
//   - default FIR control-word address
//   - control-word field positions and a builder for it
//   - error bit indices
package fir_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WRITE,
      S_VRD,
      S_COMMIT,
      S_DONE
   } state_t;

   localparam int AW = 8;
   localparam int DW = 32;

   localparam logic [7:0] CTRL_ADDR_DEF = 8'hFF;

   // control word layout: [19:16] shift, [15:8] tap_len, [7:0] enable
   localparam int CW_SHIFT_LSB = 16;
   localparam int CW_SHIFT_MSB = 19;
   localparam int CW_LEN_LSB   = 8;
   localparam int CW_LEN_MSB   = 15;
   localparam int CW_EN_LSB    = 0;
   localparam int CW_EN_MSB    = 7;

   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_VERIFY  = 1;
   localparam int ERR_LEN     = 2;

   function automatic logic [DW-1:0] ctrl_word(input logic [3:0] sh, input logic [7:0] len);
      logic [DW-1:0] w;
      w = '0;
      w[CW_SHIFT_MSB:CW_SHIFT_LSB] = sh;
      w[CW_LEN_MSB:CW_LEN_LSB]     = len;
      w[CW_EN_MSB:CW_EN_LSB]       = 8'd1;
      return w;
   endfunction

endpackage

// File: rtl/fir_coef_ram.sv
// fir_coef_ram: 256x32 simple dual-port coefficient buffer, no reset.
//   clk   - clock
//   we    - write strobe, waddr/wdata - write port
//   raddr - read address, q - registered read data (1-cycle latency)
// A read of the address being written in the same cycle returns the old word.
module fir_coef_ram
   import fir_pkg::*;
(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr];
   end

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: streams a host-filled coefficient buffer into the FIR
// register port, then writes the FIR control word.
//   host side : coef_wr/coef_addr/coef_data fill the buffer (IDLE only);
//               tap_len, shift, shift_sel sampled on an accepted start
//   status    : busy, done (1-cycle pulse), error (sticky: [0] timeout,
//               [1] verify mismatch, [2] bad length), pcm_hold
//   FIR side  : reg_addr/reg_wr/reg_rd/reg_writedata, reg_ready, reg_readdata
// Build option: define FIR_LOAD_VERIFY_EN to read back and compare each tap.
module fir_coef_loader
   import fir_pkg::*;
#(
   parameter int         SHIFT_DEFAULT = 13,
   parameter logic [7:0] CTRL_ADDR     = CTRL_ADDR_DEF,
   parameter int         TIMEOUT       = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        coef_wr,
   input  logic [7:0]  coef_addr,
   input  logic [31:0] coef_data,
   input  logic [7:0]  tap_len,
   input  logic [3:0]  shift,
   input  logic        shift_sel,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [2:0]  error,
   output logic        pcm_hold,
   output logic [7:0]  reg_addr,
   output logic        reg_wr,
   output logic        reg_rd,
   input  logic        reg_ready,
   output logic [31:0] reg_writedata,
   input  logic [31:0] reg_readdata
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t        state, state_nxt;
   logic [7:0]    idx, len_q;
   logic [3:0]    shift_q;
   logic [CW-1:0] tmo_cnt;
   logic [2:0]    err_q;
   logic [31:0]   ram_q;
   logic          ram_we, last, access, tmo_hit, vfy_bad;

   // buffer is host-writable only while idle; read address follows idx so
   // the word stays put for the whole WRITE (and VRD) access
   assign ram_we = coef_wr && (state == S_IDLE);

   fir_coef_ram u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (coef_addr),
      .wdata (coef_data),
      .raddr (idx),
      .q     (ram_q)
   );

   assign last    = (idx == len_q - 8'd1);
   assign access  = (state == S_WRITE) || (state == S_VRD) || (state == S_COMMIT);
   assign tmo_hit = access && !reg_ready && (tmo_cnt == TMO);

`ifdef FIR_LOAD_VERIFY_EN
   assign vfy_bad = (state == S_VRD) && reg_ready && (reg_readdata != ram_q);
`else
   logic unused_rd;
   assign unused_rd = ^reg_readdata;
   assign vfy_bad   = 1'b0;
`endif

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= '0;
         len_q   <= '0;
         shift_q <= '0;
         tmo_cnt <= '0;
         err_q   <= '0;
      end else begin
         state <= state_nxt;
         // any transition restarts the per-access wait count
         if (state_nxt != state || !access) tmo_cnt <= '0;
         else                               tmo_cnt <= tmo_cnt + 1'b1;

         if (state == S_IDLE && start) begin
            len_q          <= tap_len;
            shift_q        <= shift_sel ? shift : 4'(SHIFT_DEFAULT);
            idx            <= '0;
            err_q          <= '0;
            err_q[ERR_LEN] <= (tap_len == 8'd0);
         end else if (state_nxt == S_FETCH) begin
            idx <= idx + 8'd1;
         end

         if (tmo_hit) err_q[ERR_TIMEOUT] <= 1'b1;
         if (vfy_bad) err_q[ERR_VERIFY]  <= 1'b1;
      end
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = (tap_len == 8'd0) ? S_DONE : S_FETCH;
         S_FETCH:  state_nxt = S_WRITE;
         S_WRITE: begin
            if (reg_ready) begin
`ifdef FIR_LOAD_VERIFY_EN
               state_nxt = S_VRD;
`else
               state_nxt = last ? S_COMMIT : S_FETCH;
`endif
            end else if (tmo_hit) begin
               state_nxt = S_DONE;
            end
         end
`ifdef FIR_LOAD_VERIFY_EN
         S_VRD: begin
            if (reg_ready)    state_nxt = last ? S_COMMIT : S_FETCH;
            else if (tmo_hit) state_nxt = S_DONE;
         end
`endif
         S_COMMIT: if (reg_ready || tmo_hit) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // outputs decoded from registered state; bus fields are zero when idle
   always_comb begin
      busy          = (state != S_IDLE);
      pcm_hold      = (state != S_IDLE);
      done          = (state == S_DONE);
      error         = err_q;
      reg_wr        = 1'b0;
      reg_rd        = 1'b0;
      reg_addr      = '0;
      reg_writedata = '0;
      case (state)
         S_WRITE: begin
            reg_wr        = 1'b1;
            reg_addr      = idx;
            reg_writedata = ram_q;
         end
`ifdef FIR_LOAD_VERIFY_EN
         S_VRD: begin
            reg_rd   = 1'b1;
            reg_addr = idx;
         end
`endif
         S_COMMIT: begin
            reg_wr        = 1'b1;
            reg_addr      = CTRL_ADDR;
            reg_writedata = ctrl_word(shift_q, len_q);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader (TIMEOUT set to 15).
// Honours FIR_LOAD_VERIFY_EN for expected timing and the verify test.
module tb_fir_coef_loader;

`ifdef FIR_LOAD_VERIFY_EN
   localparam int TPT = 3;
`else
   localparam int TPT = 2;
`endif

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        coef_wr = 1'b0, shift_sel = 1'b0, start = 1'b0, reg_ready = 1'b0;
   logic [7:0]  coef_addr = '0, tap_len = '0;
   logic [31:0] coef_data = '0, reg_readdata = '0;
   logic [3:0]  shift = '0;
   logic        busy, done, pcm_hold, reg_wr, reg_rd;
   logic [2:0]  error;
   logic [7:0]  reg_addr;
   logic [31:0] reg_writedata;

   fir_coef_loader #(.SHIFT_DEFAULT(13), .CTRL_ADDR(8'hFF), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .coef_wr(coef_wr), .coef_addr(coef_addr),
      .coef_data(coef_data), .tap_len(tap_len), .shift(shift), .shift_sel(shift_sel),
      .start(start), .busy(busy), .done(done), .error(error), .pcm_hold(pcm_hold),
      .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_ready(reg_ready),
      .reg_writedata(reg_writedata), .reg_readdata(reg_readdata)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int mode = 0;     // 0: always ready, 1: 3-cycle stall per access, 2: never ready
   bit corrupt = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---- bus monitor (sole writer of the record variables) ----
   int cyc = 0, t0 = 0, nw = 0, done_t = -1, wr_hi = 0, both_cnt = 0, unstable = 0;
   int ph_first = 0, ph_last = 0, ph_cnt = 0, busy_last = 0, commit_seen = 0;
   logic [7:0]  wa [16];
   logic [31:0] wd [16];
   int          wt [16];
   logic [31:0] smem [256];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_a = '0;
   logic [31:0] prev_d = '0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && start && !busy) begin
         t0 = cyc; nw = 0; done_t = -1; wr_hi = 0; unstable = 0;
         ph_cnt = 0; ph_first = 0; ph_last = 0; busy_last = 0; commit_seen = 0;
      end
      if (reg_wr && reg_ready) begin
         if (nw < 16) begin
            wa[nw] = reg_addr; wd[nw] = reg_writedata; wt[nw] = cyc - t0;
         end
         nw++;
         smem[reg_addr] = reg_writedata;
      end
      if (reg_wr) wr_hi++;
      if (reg_wr && reg_rd) both_cnt++;
      if (reg_wr && reg_addr == 8'hFF) commit_seen++;
      if (prev_stall && (reg_wr || reg_rd) && (reg_addr !== prev_a || reg_writedata !== prev_d))
         unstable++;
      prev_stall = (reg_wr || reg_rd) && !reg_ready;
      prev_a = reg_addr;
      prev_d = reg_writedata;
      if (done) done_t = cyc - t0;
      if (busy) busy_last = cyc - t0;
      if (pcm_hold) begin
         if (ph_cnt == 0) ph_first = cyc - t0;
         ph_last = cyc - t0;
         ph_cnt++;
      end
   end

   // ---- FIR register slave ----
   int wcnt = 0;
   always @(negedge clk) begin
      if (reg_wr || reg_rd) begin
         reg_ready = (mode == 0) || (mode == 1 && wcnt == 3);
         wcnt = reg_ready ? 0 : wcnt + 1;
      end else begin
         reg_ready = (mode == 0);
         wcnt = 0;
      end
      reg_readdata = smem[reg_addr] ^ ((corrupt && reg_addr == 8'd2) ? 32'h1 : 32'h0);
   end

   task automatic bufwr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      coef_wr = 1'b1; coef_addr = a; coef_data = d;
      @(negedge clk);
      coef_wr = 1'b0;
   endtask

   task automatic go(input logic [7:0] len, input logic sel, input logic [3:0] sh);
      @(negedge clk);
      tap_len = len; shift_sel = sel; shift = sh; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (done_t < 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done_t >= 0), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_pcm_hold", 32'(pcm_hold), 0);
      chk("rst_wr_rd", 32'({reg_wr, reg_rd}), 0);
      chk("rst_addr", 32'(reg_addr), 0);
      chk("rst_wdata", reg_writedata, 0);
      rst_n = 1'b1;

      for (int k = 0; k < 4; k++) bufwr(8'(k), 32'h11 * (k + 1));

      // T1: 4 taps, default shift, always ready
      go(8'd4, 1'b0, 4'd0);
      wait_done(100, "t1");
      chk("t1_nwrites", nw, 5);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t1_addr%0d", k), 32'(wa[k]), 32'(k));
         chk($sformatf("t1_data%0d", k), wd[k], 32'h11 * (k + 1));
         chk($sformatf("t1_time%0d", k), wt[k], 2 + TPT * k);
      end
      chk("t1_ctrl_addr", 32'(wa[4]), 32'hFF);
      chk("t1_ctrl_data", wd[4], 32'h000D0401);
      chk("t1_ctrl_time", wt[4], TPT * 4 + 1);
      chk("t1_done_time", done_t, TPT * 4 + 2);
      chk("t1_hold_first", ph_first, 1);
      chk("t1_hold_last", ph_last, TPT * 4 + 2);
      chk("t1_busy_last", busy_last, TPT * 4 + 2);
      chk("t1_error", 32'(error), 0);

      // T2: same load, 3 stall cycles on every access
      mode = 1;
      go(8'd4, 1'b0, 4'd0);
      wait_done(300, "t2");
      chk("t2_nwrites", nw, 5);
      chk("t2_unstable", unstable, 0);
      chk("t2_tap0_time", wt[0], 5);
      chk("t2_data2", wd[2], 32'h33);
      chk("t2_ctrl_data", wd[4], 32'h000D0401);
      chk("t2_done_time", done_t, TPT * 4 + 2 + 3 * (4 * (TPT - 1) + 1));
      chk("t2_error", 32'(error), 0);

      // T3: slave never ready -> timeout after 16 request cycles
      mode = 2;
      go(8'd4, 1'b0, 4'd0);
      wait_done(100, "t3");
      chk("t3_wr_cycles", wr_hi, 16);
      chk("t3_error", 32'(error), 32'b001);
      chk("t3_nwrites", nw, 0);
      chk("t3_no_commit", commit_seen, 0);
      chk("t3_done_time", done_t, 18);
      repeat (5) @(negedge clk);
      chk("t3_error_sticky", 32'(error), 32'b001);
      mode = 0;

      // T4: zero length
      go(8'd0, 1'b0, 4'd0);
      wait_done(20, "t4");
      chk("t4_done_time", done_t, 1);
      chk("t4_error", 32'(error), 32'b100);
      chk("t4_no_wr", wr_hi, 0);

      // T5: ignored start/coef_wr while busy, then reset during tap 2
      go(8'd4, 1'b0, 4'd0);
      start = 1'b1; coef_wr = 1'b1; coef_addr = 8'd1; coef_data = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; coef_wr = 1'b0;
      n = 0;
      while (!(reg_wr === 1'b1 && reg_addr === 8'd2) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach_tap2", 32'(n < 50), 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_rst_wr", 32'(reg_wr), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_addr", 32'(reg_addr), 0);
      chk("t5_nwrites", nw, 3);
      chk("t5_tap1_time", wt[1], 2 + TPT);
      chk("t5_tap1_data", wd[1], 32'h22);
      rst_n = 1'b1;
      go(8'd4, 1'b1, 4'd5);
      wait_done(100, "t5b");
      for (int k = 0; k < 4; k++)
         chk($sformatf("t5_reread%0d", k), wd[k], 32'h11 * (k + 1));
      chk("t5_ctrl_data", wd[4], 32'h00050401);
      chk("t5_error", 32'(error), 0);

`ifdef FIR_LOAD_VERIFY_EN
      // T6: slave corrupts read-back of tap 2
      corrupt = 1'b1;
      go(8'd4, 1'b0, 4'd0);
      wait_done(100, "t6");
      chk("t6_error", 32'(error), 32'b010);
      chk("t6_nwrites", nw, 5);
      chk("t6_ctrl_addr", 32'(wa[4]), 32'hFF);
      chk("t6_done_time", done_t, 14);
      corrupt = 1'b0;
`endif

      chk("never_wr_and_rd", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
